// File: rtl/wb_sel_pkg.sv
// Shared types and constants for the write-back source selector.
//   state_e    : FSM states (StIdle, StWait)
//   ERR_*      : wb_err_code encodings
//   sel_width  : select width for a given source count, never below 1
package wb_sel_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StWait
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_SEL  = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  // $clog2(1) is 0, so clamp to a usable 1-bit select.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_source_select_if.sv
// Request/source/write-back bundle of the write-back source selector.
//   req_valid/req_sel/req_ready : request handshake
//   src_data/src_valid          : packed sources, source k at [k*DATA_W +: DATA_W]
//   wb_valid/wb_data            : write-back result (pulse / held data)
//   wb_err/wb_err_code          : abort pulse / held error code
// Modports: master drives requests and sources, slave is the selector.
interface wb_source_select_if
  import wb_sel_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SRC = 5,
  parameter int unsigned SEL_W   = sel_width(NUM_SRC)
) ();

  logic                      req_valid;
  logic [SEL_W-1:0]          req_sel;
  logic                      req_ready;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_valid;
  logic                      wb_valid;
  logic [DATA_W-1:0]         wb_data;
  logic                      wb_err;
  logic [1:0]                wb_err_code;

  modport master (
    output req_valid, req_sel, src_data, src_valid,
    input  req_ready, wb_valid, wb_data, wb_err, wb_err_code
  );

  modport slave (
    input  req_valid, req_sel, src_data, src_valid,
    output req_ready, wb_valid, wb_data, wb_err, wb_err_code
  );

endinterface

// File: rtl/wb_wait_timer.sv
// Wait-state cycle counter for the write-back selector.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : synchronous clear (wins over en_i)
//   en_i          : count one cycle
//   expired_o     : count has reached TIMEOUT-1
module wb_wait_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [15:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign expired_o = (count_q == 16'(TIMEOUT - 1));

endmodule

// File: rtl/wb_source_select.sv
// Registered, handshaked write-back source selector for the register-file write port.
// Selects one of NUM_SRC sources, waits for slow sources, and reports bad selects and
// timeouts through wb_err/wb_err_code instead of driving an undefined value.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : wb_source_select_if.slave (request, sources, write-back result, error)
// Build option: define WB_BYPASS_EN to let a request whose source is already valid at
// accept complete without passing through StWait (one result per cycle).
module wb_source_select
  import wb_sel_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SRC = 5,
  parameter int unsigned SEL_W   = sel_width(NUM_SRC),
  parameter int unsigned TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst_n,
  wb_source_select_if.slave bus
);

  state_e            state_q;
  logic [SEL_W-1:0]  sel_q;
  logic              wb_valid_q;
  logic              wb_err_q;
  logic [1:0]        err_code_q;
  logic [DATA_W-1:0] wb_data_q;

  logic              accept;
  logic              req_legal;
  logic [SEL_W-1:0]  rd_idx;
  logic [DATA_W-1:0] src_pick;
  logic              src_hit;
  logic              tmr_expired;

  assign accept    = bus.req_valid && (state_q == StIdle);
  assign req_legal = (32'(bus.req_sel) < NUM_SRC);

  // In StIdle the live request addresses the sources (bypass path); in StWait the latched
  // select does. Illegal selects are steered to source 0 so the part-select stays in range.
  always_comb begin
    rd_idx = sel_q;
    if (state_q == StIdle) begin
      rd_idx = req_legal ? bus.req_sel : '0;
    end
  end

  assign src_pick = bus.src_data[int'(rd_idx) * DATA_W +: DATA_W];
  assign src_hit  = bus.src_valid[rd_idx];

  wb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .clr_i     (state_q != StWait),
    .en_i      (state_q == StWait),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_err_q   <= 1'b0;
      err_code_q <= ERR_NONE;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      wb_err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            sel_q <= bus.req_sel;
            if (!req_legal) begin
              wb_err_q   <= 1'b1;
              err_code_q <= ERR_SEL;
`ifdef WB_BYPASS_EN
            end else if (src_hit) begin
              wb_data_q  <= src_pick;
              wb_valid_q <= 1'b1;
`endif
            end else begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          // Data arriving on the expiry cycle still completes the request.
          if (src_hit) begin
            wb_data_q  <= src_pick;
            wb_valid_q <= 1'b1;
            state_q    <= StIdle;
          end else if (tmr_expired) begin
            wb_err_q   <= 1'b1;
            err_code_q <= ERR_TMO;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready   = (state_q == StIdle);
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_err      = wb_err_q;
  assign bus.wb_err_code = err_code_q;

endmodule

// File: tb/tb_wb_source_select.sv
module tb_wb_source_select;

  localparam int unsigned DW = 32;
  localparam int unsigned NS = 5;
  localparam int unsigned SW = 3;

  logic            clk;
  logic            rst_n;
  logic            req_valid;
  logic [SW-1:0]   req_sel;
  logic [NS*DW-1:0] src_data;
  logic [NS-1:0]   src_valid;

  int total;
  int bad;

  wb_source_select_if #(.DATA_W(DW), .NUM_SRC(NS), .SEL_W(SW)) wb ();
  wb_source_select_if #(.DATA_W(DW), .NUM_SRC(NS), .SEL_W(SW)) wb8 ();

  assign wb.req_valid  = req_valid;
  assign wb.req_sel    = req_sel;
  assign wb.src_data   = src_data;
  assign wb.src_valid  = src_valid;
  assign wb8.req_valid = req_valid;
  assign wb8.req_sel   = req_sel;
  assign wb8.src_data  = src_data;
  assign wb8.src_valid = src_valid;

  wb_source_select #(
    .DATA_W (DW), .NUM_SRC (NS), .SEL_W (SW), .TIMEOUT (255)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (wb)
  );

  wb_source_select #(
    .DATA_W (DW), .NUM_SRC (NS), .SEL_W (SW), .TIMEOUT (8)
  ) u_dut_t8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (wb8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int k, input logic [31:0] v);
    src_data[k*DW +: DW] = v;
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    req_sel   = '0;
    src_valid = '0;
    rst_n     = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  logic seen_v;
  logic seen_e;
  logic seen_r;
  int   pulses;
  logic exp_v;

  initial begin
    total    = 0;
    bad      = 0;
    src_data = '0;
    do_reset();

    // Reset state
    check_val("rst_valid", 32'(wb.wb_valid), 32'd0);
    check_val("rst_err", 32'(wb.wb_err), 32'd0);
    check_val("rst_code", 32'(wb.wb_err_code), 32'd0);
    check_val("rst_data", wb.wb_data, 32'd0);
    check_val("rst_ready", 32'(wb.req_ready), 32'd1);

    // 1: reset in the middle of a wait
    req_sel = 3'd4; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    check_val("t1_ready_wait", 32'(wb.req_ready), 32'd0);
    step();
    rst_n = 1'b0;
    #1;
    check_val("t1_async_valid", 32'(wb.wb_valid), 32'd0);
    check_val("t1_async_err", 32'(wb.wb_err), 32'd0);
    check_val("t1_async_ready", 32'(wb.req_ready), 32'd1);
    step();
    rst_n = 1'b1;
    seen_v = 1'b0; seen_e = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      seen_v |= wb.wb_valid;
      seen_e |= wb.wb_err;
    end
    check_val("t1_no_valid", 32'(seen_v), 32'd0);
    check_val("t1_no_err", 32'(seen_e), 32'd0);
    check_val("t1_data", wb.wb_data, 32'd0);
    check_val("t1_code", 32'(wb.wb_err_code), 32'd0);

    // 2: RAM path, source already valid
    set_src(0, 32'hDEADBEEF);
    src_valid = 5'b00001;
    req_sel = 3'd0; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
`ifdef WB_BYPASS_EN
    check_val("t2_valid_c1", 32'(wb.wb_valid), 32'd1);
    check_val("t2_data", wb.wb_data, 32'hDEADBEEF);
    step();
    check_val("t2_valid_c2", 32'(wb.wb_valid), 32'd0);
`else
    check_val("t2_valid_c1", 32'(wb.wb_valid), 32'd0);
    step();
    check_val("t2_valid_c2", 32'(wb.wb_valid), 32'd1);
    check_val("t2_data", wb.wb_data, 32'hDEADBEEF);
    check_val("t2_ready_c2", 32'(wb.req_ready), 32'd1);
    step();
    check_val("t2_valid_c3", 32'(wb.wb_valid), 32'd0);
`endif
    src_valid = '0;

    // 3: slow HD source, valid after 10 wait cycles
    do_reset();
    set_src(4, 32'h0);
    req_sel = 3'd4; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    seen_r = 1'b0; pulses = 0;
    for (int i = 0; i < 10; i++) begin
      seen_r |= wb.req_ready;
      if (wb.wb_valid) pulses++;
      step();
    end
    check_val("t3_ready_low", 32'(seen_r), 32'd0);
    set_src(4, 32'h1234);
    src_valid = 5'b10000;
    step();
    check_val("t3_valid", 32'(wb.wb_valid), 32'd1);
    check_val("t3_data", wb.wb_data, 32'h1234);
    src_valid = '0;
    if (wb.wb_valid) pulses++;
    for (int i = 0; i < 3; i++) begin
      step();
      if (wb.wb_valid) pulses++;
    end
    check_val("t3_pulses", 32'(pulses), 32'd1);

    // 4: out-of-range selects
    req_sel = 3'd5; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    check_val("t4_err", 32'(wb.wb_err), 32'd1);
    check_val("t4_code", 32'(wb.wb_err_code), 32'd1);
    check_val("t4_valid", 32'(wb.wb_valid), 32'd0);
    check_val("t4_data_held", wb.wb_data, 32'h1234);
    check_val("t4_ready", 32'(wb.req_ready), 32'd1);
    step();
    check_val("t4_err_pulse", 32'(wb.wb_err), 32'd0);
    check_val("t4_code_held", 32'(wb.wb_err_code), 32'd1);
    req_sel = 3'd7; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    check_val("t4_err_sel7", 32'(wb.wb_err), 32'd1);
    step();

    // 5: timeout on the TIMEOUT=8 instance
    do_reset();
    req_sel = 3'd3; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    seen_e = 1'b0;
    for (int k = 1; k < 9; k++) begin
      seen_e |= wb8.wb_err;
      step();
    end
    check_val("t5_no_early_err", 32'(seen_e), 32'd0);
    check_val("t5_err_c9", 32'(wb8.wb_err), 32'd1);
    check_val("t5_code", 32'(wb8.wb_err_code), 32'd2);
    check_val("t5_valid_c9", 32'(wb8.wb_valid), 32'd0);
    check_val("t5_ready_c9", 32'(wb8.req_ready), 32'd1);
    step();
    check_val("t5_err_pulse", 32'(wb8.wb_err), 32'd0);
    check_val("t5_code_held", 32'(wb8.wb_err_code), 32'd2);
    // Valid arriving on the expiry cycle wins
    req_sel = 3'd3; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (7) step();
    set_src(3, 32'hCAFE0003);
    src_valid = 5'b01000;
    step();
    src_valid = '0;
    check_val("t5_race_valid", 32'(wb8.wb_valid), 32'd1);
    check_val("t5_race_err", 32'(wb8.wb_err), 32'd0);
    check_val("t5_race_data", wb8.wb_data, 32'hCAFE0003);
    step();
    check_val("t5_race_no_err", 32'(wb8.wb_err), 32'd0);
    check_val("t5_race_ready", 32'(wb8.req_ready), 32'd1);

    // 6: back-to-back requests on source 1; data at cycle c+j is 0x100+j-1 when valid
    do_reset();
    set_src(1, 32'h100);
    src_valid = 5'b00010;
    req_sel = 3'd1; req_valid = 1'b1;
`ifdef WB_BYPASS_EN
    for (int j = 1; j <= 5; j++) begin
      step();
      req_valid = (j < 4);
      set_src(1, 32'h100 + 32'(j));
      exp_v = (j <= 4);
`else
    for (int j = 1; j <= 9; j++) begin
      step();
      req_valid = (j < 8);
      set_src(1, 32'h100 + 32'(j));
      exp_v = (j % 2 == 0);
`endif
      check_val($sformatf("t6_valid_c%0d", j), 32'(wb.wb_valid), 32'(exp_v));
      if (exp_v) check_val($sformatf("t6_data_c%0d", j), wb.wb_data, 32'h100 + 32'(j - 1));
    end
    src_valid = '0;
    req_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
